// File: rtl/ps2_key_event_ctrl_if.sv
// Handshake bundle between the PS/2 byte receiver, the key-event sequencer
// and the event consumer. The master side drives bytes, pops and flag
// clears. The slave side (the sequencer) returns the decoded event stream
// and its status.
interface ps2_key_event_ctrl_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]       scanCode;
  logic             scanCodeReady;
  logic [7:0]       evtCode;
  logic             evtExtended;
  logic             evtRelease;
  logic             evtValid;
  logic             evtReady;
  logic [CNT_W-1:0] fifoCount;
  logic             overflow;
  logic             kbError;
  logic             clearFlags;
  logic             parserBusy;

  modport master (
    output scanCode, scanCodeReady, evtReady, clearFlags,
    input  evtCode, evtExtended, evtRelease, evtValid, fifoCount,
           overflow, kbError, parserBusy
  );

  modport slave (
    input  scanCode, scanCodeReady, evtReady, clearFlags,
    output evtCode, evtExtended, evtRelease, evtValid, fifoCount,
           overflow, kbError, parserBusy
  );
endinterface

// File: rtl/ps2_key_event_ctrl.sv
// PS/2 Set-2 key event sequencer. It parses the raw scan-code byte stream
// (E0 / F0 / E1 prefixes), filters housekeeping bytes and queues one
// {extended, release, code} event per keystroke in a first-word-fall-through
// FIFO. Sticky overflow and error flags are kept. A prefix timeout stops a
// corrupted stream from leaving the parser stuck.
module ps2_key_event_ctrl #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input logic clk,
  input logic rst,
  ps2_key_event_ctrl_if.slave bus
);

  localparam int          PTR_W    = $clog2(FIFO_DEPTH);
  localparam int          CNT_W    = PTR_W + 1;
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, GOT_E0, GOT_F0, GOT_E0F0, PAUSE
  } state_t;

  state_t           state, nxt_state;
  logic [2:0]       pause_cnt, nxt_pause;
  logic [15:0]      tmo_cnt;
  logic             push, err_set;
  logic [9:0]       push_ev;     // {extended, release, code}
  logic             kb_error, overflow_r;

  logic [9:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full, pop, wr_en, drop;
  logic [9:0]       head;

  // Prefix decoder: choose the next parser state, and whether this byte
  // (or an expired wait) produces an event or an error.
  always_comb begin
    nxt_state = state;
    nxt_pause = pause_cnt;
    push      = 1'b0;
    push_ev   = '0;
    err_set   = 1'b0;
    if (bus.scanCodeReady) begin
      case (state)
        IDLE: begin
          case (bus.scanCode)
            8'hE0: nxt_state = GOT_E0;
            8'hF0: nxt_state = GOT_F0;
            8'hE1: begin
              nxt_state = PAUSE;
              nxt_pause = 3'd7;
            end
            8'hAA, 8'hFA, 8'hEE, 8'hFE: ;
            8'h00, 8'hFF: err_set = 1'b1;
            default: begin
              push    = 1'b1;
              push_ev = {2'b00, bus.scanCode};
            end
          endcase
        end
        GOT_E0: begin
          case (bus.scanCode)
            8'hF0: nxt_state = GOT_E0F0;
            8'hE0: nxt_state = GOT_E0;
            8'hE1: begin
              err_set   = 1'b1;
              nxt_state = IDLE;
            end
            // Fake shift emitted around extended keys carries no key.
            8'h12: nxt_state = IDLE;
            default: begin
              push      = 1'b1;
              push_ev   = {2'b10, bus.scanCode};
              nxt_state = IDLE;
            end
          endcase
        end
        GOT_F0: begin
          case (bus.scanCode)
            8'hE0, 8'hE1, 8'hF0: begin
              err_set   = 1'b1;
              nxt_state = IDLE;
            end
            default: begin
              push      = 1'b1;
              push_ev   = {2'b01, bus.scanCode};
              nxt_state = IDLE;
            end
          endcase
        end
        GOT_E0F0: begin
          case (bus.scanCode)
            8'hE0, 8'hE1, 8'hF0: begin
              err_set   = 1'b1;
              nxt_state = IDLE;
            end
            8'h12: nxt_state = IDLE;
            default: begin
              push      = 1'b1;
              push_ev   = {2'b11, bus.scanCode};
              nxt_state = IDLE;
            end
          endcase
        end
        PAUSE: begin
          // The content of the pause sequence is fixed; only its length matters.
          nxt_pause = pause_cnt - 3'd1;
          if (pause_cnt == 3'd1) begin
            push      = 1'b1;
            push_ev   = {2'b10, 8'hE1};
            nxt_state = IDLE;
          end
        end
        default: nxt_state = IDLE;
      endcase
    end else if (state != IDLE && tmo_cnt == TMO_LAST) begin
      nxt_state = IDLE;
      err_set   = 1'b1;
    end
  end

  // Parser state, pause length, prefix timeout and the sticky error flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      pause_cnt <= '0;
      tmo_cnt   <= '0;
      kb_error  <= 1'b0;
    end else begin
      state     <= nxt_state;
      pause_cnt <= nxt_pause;
      if (bus.scanCodeReady || state == IDLE)
        tmo_cnt <= '0;
      else
        tmo_cnt <= tmo_cnt + 16'd1;
      kb_error  <= err_set | (kb_error & ~bus.clearFlags);
    end
  end

  assign full  = (count == CNT_W'(FIFO_DEPTH));
  assign pop   = (count != '0) & bus.evtReady;
  assign wr_en = push & (~full | pop);
  assign drop  = push & full & ~pop;

  // FIFO pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_r <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      overflow_r <= drop | (overflow_r & ~bus.clearFlags);
    end
  end

  // Event storage. A full FIFO that pushes and pops together overwrites the
  // slot being popped, which is safe because the read is taken before the edge.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_ev;
  end

  assign head            = (count != '0) ? mem[rd_ptr] : 10'd0;
  assign bus.evtCode     = head[7:0];
  assign bus.evtRelease  = head[8];
  assign bus.evtExtended = head[9];
  assign bus.evtValid    = (count != '0);
  assign bus.fifoCount   = count;
  assign bus.overflow    = overflow_r;
  assign bus.kbError     = kb_error;
  assign bus.parserBusy  = (state != IDLE);

endmodule

// File: tb/tb_ps2_key_event_ctrl.sv
// Bench for the PS/2 key event sequencer. A behavioural model tracks the
// collected prefix bytes, the remaining pause length, an event queue and the
// flags. It is compared with the DUT outputs on every falling edge.
// Directed sequences also pin literal expected values.
module tb_ps2_key_event_ctrl;
  localparam int DEPTH = 4;
  localparam int TMO   = 8;

  logic clk;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  ps2_key_event_ctrl_if #(.FIFO_DEPTH(DEPTH)) bus ();

  ps2_key_event_ctrl #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void check(input string name, input logic [31:0] got,
                                input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endfunction

  // ---------------- behavioural model ----------------
  logic [9:0] mq[$];        // queued events {ext, rel, code}
  logic [7:0] pend[$];      // prefix bytes collected so far
  int         pause_left = 0;
  int         wait_cnt   = 0;
  bit         m_ovf = 0, m_err = 0;
  bit         m_push, m_errset, m_ovfset, m_pop;
  logic [9:0] m_ev;
  logic [9:0] m_head;

  function automatic bit has_byte(input logic [7:0] b);
    foreach (pend[i]) if (pend[i] == b) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_byte(input logic [7:0] b, output bit push,
                                     output logic [9:0] ev, output bit err);
    bit e0, f0;
    push = 0; err = 0; ev = '0;
    if (pause_left > 0) begin
      pause_left--;
      if (pause_left == 0) begin push = 1; ev = {2'b10, 8'hE1}; end
    end else if (pend.size() == 0) begin
      if (b == 8'hE0 || b == 8'hF0) pend.push_back(b);
      else if (b == 8'hE1) pause_left = 7;
      else if (b == 8'hAA || b == 8'hFA || b == 8'hEE || b == 8'hFE) ;
      else if (b == 8'h00 || b == 8'hFF) err = 1;
      else begin push = 1; ev = {2'b00, b}; end
    end else begin
      e0 = has_byte(8'hE0);
      f0 = has_byte(8'hF0);
      if (b == 8'hF0 && e0 && !f0) pend.push_back(b);
      else if (b == 8'hE0 && e0 && !f0) ;
      else if (b == 8'hE0 || b == 8'hE1 || b == 8'hF0) begin err = 1; pend.delete(); end
      else if (b == 8'h12 && e0) pend.delete();
      else begin push = 1; ev = {e0, f0, b}; pend.delete(); end
    end
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete(); pend.delete();
      pause_left = 0; wait_cnt = 0; m_ovf = 0; m_err = 0;
    end else begin
      m_push = 0; m_errset = 0; m_ovfset = 0; m_ev = '0;
      if (bus.scanCodeReady) begin
        wait_cnt = 0;
        model_byte(bus.scanCode, m_push, m_ev, m_errset);
      end else if (pend.size() != 0 || pause_left != 0) begin
        if (wait_cnt == TMO - 1) begin
          pend.delete(); pause_left = 0; wait_cnt = 0; m_errset = 1;
        end else wait_cnt++;
      end else wait_cnt = 0;
      m_pop = (mq.size() != 0) && bus.evtReady;
      if (m_pop) void'(mq.pop_front());
      if (m_push) begin
        if (mq.size() < DEPTH) mq.push_back(m_ev);
        else m_ovfset = 1;
      end
      m_err = m_errset  ? 1'b1 : (bus.clearFlags ? 1'b0 : m_err);
      m_ovf = m_ovfset  ? 1'b1 : (bus.clearFlags ? 1'b0 : m_ovf);
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    m_head = (mq.size() != 0) ? mq[0] : 10'd0;
    check("m_evtValid",    32'(bus.evtValid),    32'(mq.size() != 0));
    check("m_evtCode",     32'(bus.evtCode),     32'(m_head[7:0]));
    check("m_evtRelease",  32'(bus.evtRelease),  32'(m_head[8]));
    check("m_evtExtended", 32'(bus.evtExtended), 32'(m_head[9]));
    check("m_fifoCount",   32'(bus.fifoCount),   32'(mq.size()));
    check("m_overflow",    32'(bus.overflow),    32'(m_ovf));
    check("m_kbError",     32'(bus.kbError),     32'(m_err));
    check("m_parserBusy",  32'(bus.parserBusy),  32'(pend.size() != 0 || pause_left != 0));
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [7:0] b);
    bus.scanCode      = b;
    bus.scanCodeReady = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    bus.scanCodeReady = 1'b0;
    bus.scanCode      = 8'h00;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pop_n(input int n);
    bus.evtReady = 1'b1;
    idle(n);
    bus.evtReady = 1'b0;
  endtask

  task automatic clear_flags();
    bus.clearFlags = 1'b1;
    idle(1);
    bus.clearFlags = 1'b0;
  endtask

  task automatic check_head(input string name, input logic ext, input logic rel,
                            input logic [7:0] code);
    check({name, "_valid"}, 32'(bus.evtValid), 32'd1);
    check({name, "_ext"},   32'(bus.evtExtended), 32'(ext));
    check({name, "_rel"},   32'(bus.evtRelease),  32'(rel));
    check({name, "_code"},  32'(bus.evtCode),     32'(code));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [7:0] pause_seq [6] = '{8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0};
  logic [7:0] e0_seq [10]   = '{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75,
                                8'hE0, 8'h12, 8'hE0, 8'hF0, 8'h12};
  logic [7:0] fill_seq [5]  = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C};

  initial begin
    rst               = 1'b0;
    bus.scanCode      = 8'h00;
    bus.scanCodeReady = 1'b0;
    bus.evtReady      = 1'b0;
    bus.clearFlags    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(bus.evtValid),   32'd0);
    check("rst_count", 32'(bus.fifoCount),  32'd0);
    check("rst_busy",  32'(bus.parserBusy), 32'd0);
    check("rst_err",   32'(bus.kbError),    32'd0);
    rst = 1'b1;
    idle(2);

    // Make then break of one key, consumer always ready.
    bus.evtReady = 1'b1;
    send(8'h1C);
    check_head("make", 1'b0, 1'b0, 8'h1C);
    idle(1);
    check("make_drained", 32'(bus.fifoCount), 32'd0);
    send(8'hF0);
    check("f0_busy", 32'(bus.parserBusy), 32'd1);
    check("f0_noevt", 32'(bus.evtValid), 32'd0);
    send(8'h1C);
    check_head("break", 1'b0, 1'b1, 8'h1C);
    idle(1);
    check("break_drained", 32'(bus.fifoCount), 32'd0);
    bus.evtReady = 1'b0;

    // Extended keys and fake shifts.
    foreach (e0_seq[i]) send(e0_seq[i]);
    idle(1);
    check("ext_count", 32'(bus.fifoCount), 32'd2);
    check_head("ext_make", 1'b1, 1'b0, 8'h75);
    check("ext_noerr", 32'(bus.kbError), 32'd0);
    pop_n(1);
    check_head("ext_break", 1'b1, 1'b1, 8'h75);
    pop_n(1);
    check("ext_drained", 32'(bus.fifoCount), 32'd0);

    // Pause sequence: eight bytes, one event.
    send(8'hE1);
    check("pause_busy1", 32'(bus.parserBusy), 32'd1);
    foreach (pause_seq[i]) send(pause_seq[i]);
    check("pause_busy7", 32'(bus.parserBusy), 32'd1);
    check("pause_noevt", 32'(bus.fifoCount), 32'd0);
    send(8'h77);
    check("pause_idle", 32'(bus.parserBusy), 32'd0);
    check("pause_count", 32'(bus.fifoCount), 32'd1);
    check_head("pause", 1'b1, 1'b0, 8'hE1);
    idle(1);
    pop_n(1);

    // Overflow, full push+pop, flag clear.
    foreach (fill_seq[i]) send(fill_seq[i]);
    idle(1);
    check("full_count", 32'(bus.fifoCount), 32'd4);
    check("full_ovf", 32'(bus.overflow), 32'd1);
    check_head("full_head", 1'b0, 1'b0, 8'h15);
    bus.evtReady = 1'b1;
    send(8'h3C);
    bus.evtReady = 1'b0;
    check("pushpop_count", 32'(bus.fifoCount), 32'd4);
    check_head("pushpop_head", 1'b0, 1'b0, 8'h1D);
    idle(1);
    clear_flags();
    check("ovf_cleared", 32'(bus.overflow), 32'd0);
    pop_n(4);
    check("full_drained", 32'(bus.fifoCount), 32'd0);

    // Housekeeping bytes dropped, error bytes flagged, set beats clear.
    send(8'hAA); send(8'hFA); send(8'hEE); send(8'hFE);
    idle(1);
    check("hk_count", 32'(bus.fifoCount), 32'd0);
    check("hk_noerr", 32'(bus.kbError), 32'd0);
    send(8'h00);
    check("err00", 32'(bus.kbError), 32'd1);
    idle(1);
    bus.clearFlags = 1'b1;
    send(8'hFF);
    bus.clearFlags = 1'b0;
    check("set_wins", 32'(bus.kbError), 32'd1);
    idle(1);
    clear_flags();
    check("err_cleared", 32'(bus.kbError), 32'd0);

    // Prefix timeout.
    send(8'hF0);
    idle(TMO - 1);
    check("tmo_still_busy", 32'(bus.parserBusy), 32'd1);
    check("tmo_no_err_yet", 32'(bus.kbError), 32'd0);
    idle(1);
    check("tmo_idle", 32'(bus.parserBusy), 32'd0);
    check("tmo_err", 32'(bus.kbError), 32'd1);
    send(8'h1C);
    check_head("after_tmo", 1'b0, 1'b0, 8'h1C);
    idle(1);
    pop_n(1);
    clear_flags();

    // Asynchronous reset mid-cycle with queued events and a pending prefix.
    send(8'h11); send(8'h22); send(8'h33); send(8'hE0);
    bus.scanCodeReady = 1'b0;
    check("pre_rst_count", 32'(bus.fifoCount), 32'd3);
    #3;
    rst = 1'b0;
    #1;
    check("arst_valid", 32'(bus.evtValid),    32'd0);
    check("arst_code",  32'(bus.evtCode),     32'd0);
    check("arst_ext",   32'(bus.evtExtended), 32'd0);
    check("arst_rel",   32'(bus.evtRelease),  32'd0);
    check("arst_count", 32'(bus.fifoCount),   32'd0);
    check("arst_ovf",   32'(bus.overflow),    32'd0);
    check("arst_err",   32'(bus.kbError),     32'd0);
    check("arst_busy",  32'(bus.parserBusy),  32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    idle(1);
    send(8'h1C);
    check_head("post_rst", 1'b0, 1'b0, 8'h1C);
    check("post_rst_count", 32'(bus.fifoCount), 32'd1);
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
